// File: rtl/shift_arbiter_if.sv
// Handshake bundle between the two Execute-stage shift requesters, the shared
// shifter arbiter and the downstream result consumer.
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_data;
  logic [3:0]  req0_amt;
  logic [1:0]  req0_mode;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_data;
  logic [3:0]  req1_amt;
  logic [1:0]  req1_mode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        rsp_err;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_mode,
    output req1_valid, req1_data, req1_amt, req1_mode,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_mode,
    input  req1_valid, req1_data, req1_amt, req1_mode,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter for the shared shifter with a one-entry result buffer.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module shift_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  io_arb
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_can_accept;
  logic        w_sel;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_grant;
  logic [15:0] w_op_data;
  logic [3:0]  w_op_amt;
  logic [1:0]  w_op_mode;
  logic [15:0] w_shift_out;
  logic [15:0] r_rsp_data;
  logic        r_rsp_id;
  logic        r_rsp_err;

`ifdef SHIFT_ARB_RR_EN
  logic r_last_grant;

  // Pointer resets to 1 so requester 0 wins the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_last_grant <= w_sel;
    end
  end

  assign w_sel = (io_arb.req0_valid && io_arb.req1_valid) ? ~r_last_grant
                                                          : ~io_arb.req0_valid;
`else
  assign w_sel = ~io_arb.req0_valid;
`endif

  // Readies are gated by rst_n so neither requester sees a grant during reset.
  always_comb begin
    w_state_next = r_state;
    w_can_accept = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_can_accept = 1'b1;
        if (w_grant) begin
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        w_can_accept = io_arb.rsp_ready;
        if (io_arb.rsp_ready && !w_grant) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    w_grant0 = rst_n & w_can_accept & io_arb.req0_valid & ~w_sel;
    w_grant1 = rst_n & w_can_accept & io_arb.req1_valid &  w_sel;
    w_grant  = w_grant0 | w_grant1;
  end

  assign w_op_data = w_sel ? io_arb.req1_data : io_arb.req0_data;
  assign w_op_amt  = w_sel ? io_arb.req1_amt  : io_arb.req0_amt;
  assign w_op_mode = w_sel ? io_arb.req1_mode : io_arb.req0_mode;

  always_comb begin
    w_shift_out = w_op_data;
    case (w_op_mode)
      2'd0:    w_shift_out = w_op_data << w_op_amt;
      2'd1:    w_shift_out = $signed(w_op_data) >>> w_op_amt;
      2'd2:    w_shift_out = (w_op_data >> w_op_amt) |
                             (w_op_data << (5'd16 - {1'b0, w_op_amt}));
      default: w_shift_out = w_op_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= 16'h0000;
      r_rsp_id   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_grant) begin
      r_rsp_data <= w_shift_out;
      r_rsp_id   <= w_sel;
      r_rsp_err  <= (w_op_mode == 2'd3);
    end
  end

  assign io_arb.req0_ready = w_grant0;
  assign io_arb.req1_ready = w_grant1;
  assign io_arb.rsp_valid  = (r_state == ST_FULL);
  assign io_arb.rsp_data   = r_rsp_data;
  assign io_arb.rsp_id     = r_rsp_id;
  assign io_arb.rsp_err    = r_rsp_err;

endmodule
